// File: rtl/button_debouncer.sv
// Debounces one raw mechanical input into a clean level plus one-cycle rise/fall pulses.
// Define BUTTON_DEBOUNCER_SYNC2_EN for a two-flop synchronizer; otherwise Din is sampled by one flop.
module button_debouncer #(
    parameter int STABLE_COUNT = 16,
    parameter int CNT_WIDTH    = 4
) (
    input  logic Clk,
    input  logic nSReset,
    input  logic Din,
    input  logic SampleEn,
    output logic Dout,
    output logic RisePulse,
    output logic FallPulse
);

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 rise_nxt, fall_nxt;
    logic                 samp;

`ifdef BUTTON_DEBOUNCER_SYNC2_EN
    logic sync1;

    always_ff @(posedge Clk) begin
        if (!nSReset) begin
            sync1 <= 1'b0;
            samp  <= 1'b0;
        end else begin
            sync1 <= Din;
            samp  <= sync1;
        end
    end
`else
    always_ff @(posedge Clk) begin
        if (!nSReset) samp <= 1'b0;
        else          samp <= Din;
    end
`endif

    assign Dout = (state == STABLE_HI);

    // Any agreement between samp and Dout clears the count, even between enable ticks.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (samp == Dout) begin
            cnt_nxt = '0;
        end else if (SampleEn) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                if (state == STABLE_LO) begin
                    state_nxt = STABLE_HI;
                    rise_nxt  = 1'b1;
                end else begin
                    state_nxt = STABLE_LO;
                    fall_nxt  = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!nSReset) begin
            state     <= STABLE_LO;
            cnt       <= '0;
            RisePulse <= 1'b0;
            FallPulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            RisePulse <= rise_nxt;
            FallPulse <= fall_nxt;
        end
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions one raw, asynchronous, bouncing input (pushbutton or switch) into a clean, clock-synchronous level plus single-cycle rise/fall pulses. Sits directly upstream of the team's D flip-flop and register stages: its `Dout` is the only signal from a mechanical input that may drive a flip-flop `Din`. Built from a synchronizer, a stability counter and a two-level state machine.

## Interface
- `STABLE_COUNT`, default 16: number of consecutive qualifying cycles the sampled input must differ from `Dout` before `Dout` changes. Legal range is 1 to 2**`CNT_WIDTH`.
- `CNT_WIDTH`, default 4: stability counter width.
- `Clk`  input  1  clock. All state updates on the rising edge.
- `nSReset`  input  1  reset, synchronous and active-low.
- `Din`  input  1  raw input, asynchronous to `Clk`, may bounce.
- `SampleEn`  input  1  count-enable tick. Tie high to count every cycle.
- `Dout`  output  1  debounced level, registered.
- `RisePulse`  output  1  high for exactly one cycle when `Dout` goes 0→1.
- `FallPulse`  output  1  high for exactly one cycle when `Dout` goes 1→0.

## Operation
- **Sampler:** `Din` passes through the synchronizer chain; the last stage is `samp`.
- **State machine:** two states, `STABLE_LO` (`Dout`=0) and `STABLE_HI` (`Dout`=1). `Dout` is decoded from the state register.
- **Counter clear:** `cnt` clears to 0 on any cycle where `samp` == `Dout`. This applies regardless of `SampleEn`, so glitches between ticks are still rejected.
- **Counter advance:** when `samp` != `Dout` and `SampleEn`=1:
  - if `cnt` == `STABLE_COUNT`-1, the state toggles, `cnt` clears to 0, and the matching pulse is asserted.
  - otherwise `cnt` increments by 1.
- **Counter hold:** when `samp` != `Dout` and `SampleEn`=0, `cnt` holds and no toggle occurs.
- **Counter range:** `cnt` never exceeds `STABLE_COUNT`-1 and never wraps.
- **Pulses:** registered. `RisePulse`/`FallPulse` are asserted in the same cycle `Dout` first shows its new value, and deassert the next cycle. The two are never high together.
- **Reset:** `nSReset`=0 at a rising edge forces state `STABLE_LO`, `Dout`=0, `cnt`=0, `RisePulse`=0, `FallPulse`=0, and all synchronizer flops to 0.
  - Reset mid-count abandons the count.
  - No pulse is generated by reset, even if `Dout` was 1.
  - Reset has priority over every other event.

## Timing
- **Reference edge:** let E0 be the first edge at which the first synchronizer flop captures a new `Din` value that then stays constant, with `SampleEn`=1 continuously.
- **Latency:**
  - `Dout` changes at edge E0+`STABLE_COUNT`+1 when the synchronizer is enabled.
  - `Dout` changes at edge E0+`STABLE_COUNT` when it is disabled.
- **With `SampleEn` gated:** the `STABLE_COUNT` term counts only edges with `SampleEn`=1 while `samp` differs from `Dout`.
- **`STABLE_COUNT`=1:** `Dout` follows `samp` with one edge of latency.
- **Bounce:** a bounce shorter than `STABLE_COUNT` qualifying cycles never changes `Dout`; any return of `samp` to `Dout` restarts the count from 0.
- **Simultaneous events:** toggle and counter clear happen on the same edge. A `samp` reversal on the toggle edge restarts counting in the opposite direction the next cycle.
- **After `nSReset` deasserts:** a `Din` held at 1 produces `Dout`=1 and `RisePulse` after the normal latency.

## Configuration
- Macro: `BUTTON_DEBOUNCER_SYNC2_EN`.
- **Defined:** two-flop synchronizer on `Din`. This is the required setting for any truly asynchronous source.
- **Not defined:** single sampling flop, one edge less latency. Only for `Din` already synchronous to `Clk`.
- Pulse, counter and reset behaviour are identical in both builds.

## Test plan
- **Clean rise:** sync enabled, `STABLE_COUNT`=16, `SampleEn`=1; `Din` 0→1 captured at E0 and held → `Dout`=1 and `RisePulse`=1 for one cycle at E0+17; `FallPulse` stays 0.
- **Bounce rejection:** `Din` toggles 1,0,1,0 with 5-cycle high segments, then holds 1 → `Dout` stays 0 through the bounce and rises exactly 17 edges after the final capture.
- **Enable gating:** `SampleEn` high every 4th cycle, `STABLE_COUNT`=4, `Din` held 1 → `Dout` rises on the 4th qualifying tick edge. `Din` dropping back to 0 for one cycle between ticks → count restarts.
- **Reset mid-operation:**
  - `nSReset`=0 at `cnt`=10 with `Dout`=0 → `cnt`=0 next edge.
  - `nSReset`=0 with `Dout`=1 → `Dout`=0 next edge and both pulses remain 0.
- **Edge cases:**
  - `STABLE_COUNT`=1, macro undefined: `Din` square wave of period 4 → `Dout` follows with 1 edge of latency, and every transition produces exactly one matching pulse.
  - `STABLE_COUNT`=2**`CNT_WIDTH`: no counter wrap, and `Dout` changes at the exact latency.
